// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: shared definitions for the DIV/DIVU sequencer.
//   - default widths for the datapath and iteration counter
//   - state encoding of the sequencer FSM (IDLE = 0 .. DONE = 4, 3 bits)
package div_sequencer_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RUN   = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: bundle between the EX stage and the divide sequencer.
//   master (EX stage / pipeline control): drives start, is_signed, dividend,
//          divisor; receives stall, busy, done, hilo_we, quotient, remainder,
//          div_by_zero.
//   slave  (div_sequencer): the mirror image.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             stall;
    logic             busy;
    logic             done;
    logic             hilo_we;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  stall, busy, done, hilo_we, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output stall, busy, done, hilo_we, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_sequencer_div_step.sv
// div_step: one combinational restoring-division step.
//   rem, q       current partial remainder and quotient/dividend shift register
//   divisor_abs  divisor magnitude
//   rem_next     partial remainder after shift and conditional subtract
//   q_next       q shifted left with the new quotient bit in bit 0
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor_abs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        // {rem, q} << 1: the MSB of q moves into the remainder. One extra bit
        // keeps the compare exact when rem has its top bit set.
        shifted  = {rem, q[WIDTH-1]};
        diff     = shifted - {1'b0, divisor_abs};
        ge       = (shifted >= {1'b0, divisor_abs});
        // When no subtract happens, shifted < divisor_abs, so its top bit is 0.
        rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU unit for the 5-stage pipeline.
//   clk    pipeline clock
//   reset  synchronous, active-high; aborts any operation in flight
//   bus    div_sequencer_if.slave: start/is_signed/dividend/divisor in;
//          stall/busy/done/hilo_we/quotient/remainder/div_by_zero out
// A nonzero divide takes WIDTH+3 cycles from the start cycle to done; a
// divide by zero finishes in 2 cycles with quotient all ones and
// remainder = dividend.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    div_sequencer_if.slave bus
);
    div_state_e       state_q, state_d;

    logic [WIDTH-1:0] dividend_q, divisor_q;
    logic             signed_q;
    logic [WIDTH-1:0] rem_q, q_q, divisor_abs_q;
    logic             neg_q_q, neg_r_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             div_by_zero_q;

    logic [WIDTH-1:0] rem_nx, q_nx;
    logic             dividend_neg, divisor_neg;
    logic [WIDTH-1:0] dividend_abs, divisor_abs;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem_q),
        .q           (q_nx_src()),
        .divisor_abs (divisor_abs_q),
        .rem_next    (rem_nx),
        .q_next      (q_nx)
    );

    function automatic logic [WIDTH-1:0] q_nx_src();
        return q_q;
    endfunction

    // Magnitudes are only taken for DIV; DIVU operands are used as-is.
    assign dividend_neg = signed_q & dividend_q[WIDTH-1];
    assign divisor_neg  = signed_q & divisor_q[WIDTH-1];
    assign dividend_abs = dividend_neg ? -dividend_q : dividend_q;
    assign divisor_abs  = divisor_neg  ? -divisor_q  : divisor_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bus.stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.stall = bus.start;
                if (bus.start) state_d = SETUP;
            end
            SETUP: begin
                bus.stall = 1'b1;
                state_d   = (divisor_q == '0) ? DONE : RUN;
            end
            RUN: begin
                bus.stall = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                bus.stall = 1'b1;
                state_d   = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.hilo_we     = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dividend_q    <= '0;
            divisor_q     <= '0;
            signed_q      <= 1'b0;
            rem_q         <= '0;
            q_q           <= '0;
            divisor_abs_q <= '0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            cnt_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        dividend_q    <= bus.dividend;
                        divisor_q     <= bus.divisor;
                        signed_q      <= bus.is_signed;
                        div_by_zero_q <= 1'b0;
                    end
                end
                SETUP: begin
                    if (divisor_q == '0) begin
                        quotient_q    <= '1;
                        remainder_q   <= dividend_q;
                        div_by_zero_q <= 1'b1;
                    end else begin
                        // q starts as |dividend| and is shifted out into rem
                        // while the quotient bits shift in from the bottom.
                        q_q           <= dividend_abs;
                        divisor_abs_q <= divisor_abs;
                        rem_q         <= '0;
                        neg_q_q       <= dividend_neg ^ divisor_neg;
                        neg_r_q       <= dividend_neg;
                        cnt_q         <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    rem_q <= rem_nx;
                    q_q   <= q_nx;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    // neg flags are already zero for DIVU. MIN / -1 wraps to
                    // MIN here through the truncated negate.
                    quotient_q  <= neg_q_q ? -q_q   : q_q;
                    remainder_q <= neg_r_q ? -rem_q : rem_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed, table-driven bench for div_sequencer.
// Cycle 0 is the cycle whose closing edge samples start; inputs are driven
// and outputs sampled on the falling edge.
module tb_div_sequencer;
    localparam int WIDTH = 32;

    typedef struct {
        bit          is_signed;
        logic [31:0] dividend;
        logic [31:0] divisor;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        bit          exp_dbz;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    div_sequencer_if #(.WIDTH(WIDTH)) bus ();

    div_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one divide. repulse_cyc > 0 re-asserts start (9/3 signed) in that
    // cycle; start_in_done asserts start in the done cycle. Both must be
    // ignored by the DUT.
    task automatic run_div(input string tag, input vec_t v, input int repulse_cyc,
                           input bit start_in_done);
        int lat;
        bit stall_ok;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = v.is_signed;
        bus.dividend  = v.dividend;
        bus.divisor   = v.divisor;
        #1;
        check({tag, " stall_c0"}, 64'(bus.stall), 64'd1);
        check({tag, " busy_c0"}, 64'(bus.busy), 64'd0);
        lat      = -1;
        stall_ok = 1'b1;
        for (int cyc = 1; cyc <= 60 && lat < 0; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = cyc;
                check({tag, " stall_at_done"}, 64'(bus.stall), 64'd0);
                check({tag, " hilo_we"}, 64'(bus.hilo_we), 64'd1);
                check({tag, " quotient"}, 64'(bus.quotient), 64'(v.exp_q));
                check({tag, " remainder"}, 64'(bus.remainder), 64'(v.exp_r));
                check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(v.exp_dbz));
                bus.start     = start_in_done;
                bus.is_signed = 1'b1;
                bus.dividend  = 32'd9;
                bus.divisor   = 32'd3;
            end else begin
                if (!bus.stall || !bus.busy || bus.hilo_we) stall_ok = 1'b0;
                bus.start     = (cyc == repulse_cyc);
                bus.is_signed = $urandom_range(0, 1);
                bus.dividend  = (cyc == repulse_cyc) ? 32'd9 : $urandom;
                bus.divisor   = (cyc == repulse_cyc) ? 32'd3 : $urandom;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " stall_busy_window"}, 64'(stall_ok), 64'd1);
        @(negedge clk);
        check({tag, " idle_after"}, 64'(bus.busy), 64'd0);
        check({tag, " done_once"}, 64'(bus.done), 64'd0);
        check({tag, " q_held"}, 64'(bus.quotient), 64'(v.exp_q));
        check({tag, " dbz_held"}, 64'(bus.div_by_zero), 64'(v.exp_dbz));
        bus.start = 1'b0;
    endtask

    vec_t vecs[10];
    vec_t v;
    int   done_seen;

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 35};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 35};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 35};
        vecs[3] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 2};
        vecs[4] = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 2};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 35};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 35};
        vecs[7] = '{1'b0, 32'd7,          32'd9,          32'd0,          32'd7,          1'b0, 35};
        vecs[8] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 35};
        vecs[9] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 35};

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst stall", 64'(bus.stall), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst quotient", 64'(bus.quotient), 64'd0);
        check("rst remainder", 64'(bus.remainder), 64'd0);
        check("rst dbz", 64'(bus.div_by_zero), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_div($sformatf("vec%0d", i), vecs[i], 0, (i == 0));

        // Start re-pulsed during RUN is ignored; the follow-up 9/3 from IDLE runs.
        run_div("repulse", vecs[0], 10, 1'b0);
        v = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 35};
        run_div("after_repulse", v, 0, 1'b0);

        // Reset mid-RUN aborts with all outputs cleared and no done pulse.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        done_seen     = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) done_seen++;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst stall", 64'(bus.stall), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        check("midrst hilo_we", 64'(bus.hilo_we), 64'd0);
        check("midrst quotient", 64'(bus.quotient), 64'd0);
        check("midrst remainder", 64'(bus.remainder), 64'd0);
        check("midrst dbz", 64'(bus.div_by_zero), 64'd0);
        reset = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("midrst no_done", 64'(done_seen), 64'd0);
        run_div("after_reset", vecs[0], 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller and datapath for the DIV instruction in the 5-stage MIPS pipeline.
- Control marks DIV as non-writing to the register file. This block takes the DIV operands from the EX stage and runs a restoring shift-subtract division, one bit per cycle.
- It stalls the pipeline while busy and delivers quotient/remainder with a one-cycle HI/LO write strobe.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  EX stage holds a valid DIV (opcode == `DIV from Opcode.vh); sampled only in IDLE.
- is_signed  in  1  1 = DIV semantics, 0 = DIVU semantics; latched with start.
- dividend  in  WIDTH  rs value; latched with start.
- divisor  in  WIDTH  rt value; latched with start.
- stall  out  1  freeze PC, IF/ID, ID/EX; insert bubble into EX/MEM.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse; results valid.
- hilo_we  out  1  equals done; write strobe for HI/LO.
- quotient  out  WIDTH  to LO.
- remainder  out  WIDTH  to HI.
- div_by_zero  out  1  divisor was zero; valid with done, held until next start.

Behaviour:
- Reset value of all outputs and registers is 0, and state goes to IDLE. Reset at any time, including mid-RUN, aborts the operation; no done is issued.
- States: IDLE, SETUP, RUN, FIX, DONE. State is registered; stall is combinational.
- IDLE:
  - On start, latch operands and is_signed, then go to SETUP.
  - stall = start, so the DIV is held in EX from the first cycle.
- SETUP:
  - If divisor == 0: quotient <= all ones, remainder <= latched dividend, div_by_zero <= 1, go to DONE. Skip FIX even when signed.
  - Otherwise: store |dividend| and |divisor| when is_signed (plain values when unsigned), record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend). Set partial remainder to 0, counter to WIDTH, go to RUN.
- RUN, one step per cycle:
  - {rem, q} shifted left 1.
  - If rem >= divisor_abs: subtract and set q[0] = 1.
  - Counter decrements; after the WIDTH-th step go to FIX.
- FIX: when is_signed, quotient = neg_q ? -q : q and remainder = neg_r ? -rem : rem (two's-complement, truncated to WIDTH). Go to DONE.
- DONE: done = hilo_we = 1 for exactly one cycle, stall = 0, then go to IDLE. quotient, remainder and div_by_zero hold until the next accepted start.
- stall = (IDLE & start) | SETUP | RUN | FIX. busy = state != IDLE.
- Latency from the cycle start is sampled (cycle 0):
  - Nonzero divisor: done in cycle WIDTH+3 (35 for WIDTH = 32).
  - Zero divisor: done in cycle 2.
- Signed overflow: MIN / -1 gives quotient = MIN and remainder = 0. This falls out of the unsigned magnitude path; no special case.
- start while busy: ignored, and operand inputs are ignored.
- start in the DONE cycle: ignored. The pipeline has advanced, so a following DIV presents start in IDLE on the next cycle.
- Operand inputs changing after the start cycle have no effect.

Decomposition:
- Opcode.vh (shared) supplies `DIV and `DIVU. A new div_defs.vh holds the state encodings (IDLE = 0 .. DONE = 4, 3 bits).
- Sub-module div_step (combinational): inputs rem, q, divisor_abs; outputs next rem, next q for one restoring step. The sequencer instantiates it once.

Test Plan:
- Unsigned 100/7, is_signed = 0, start one cycle → stall high cycles 0–34; done in cycle 35 with quotient = 14, remainder = 2, div_by_zero = 0.
- Signed -7/2 (0xFFFFFFF9 / 2) → quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF; 7 / -2 → quotient = 0xFFFFFFFD, remainder = 1.
- 5/0, either signedness → done in cycle 2, quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1; stall high cycles 0–1 only.
- Signed 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0, done in cycle 35.
- Start 100/7, re-pulse start with 9/3 during RUN → no restart, results 14/2. Then issue 9/3 from IDLE → 3/0.
- Start 100/7, assert reset in cycle 10 → next cycle state IDLE and all outputs 0; no done pulse. A fresh start then completes normally.
